// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared state encoding and branch funct3 codes for the branch resolve unit
package branch_resolve_unit_pkg;

   typedef enum logic [1:0] {
      BRU_IDLE  = 2'd0,
      BRU_REQ   = 2'd1,
      BRU_FLUSH = 2'd2
   } bru_state_e;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   function automatic logic is_reserved_funct3(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_branch_cond.sv
// rtl/branch_resolve_unit_branch_cond.sv - combinational RV32I branch condition from ALU SUB flags
module branch_cond
   import branch_resolve_unit_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       cf,
   input  logic       zf,
   input  logic       vf,
   input  logic       sf,
   output logic       cond,
   output logic       bad_funct3_raw
);

   // cf=1 means a >= b unsigned (no borrow out of the subtraction)
   always_comb begin
      cond           = 1'b0;
      bad_funct3_raw = is_reserved_funct3(funct3);
      case (funct3)
         BR_BEQ:  cond = zf;
         BR_BNE:  cond = !zf;
         BR_BLT:  cond = sf ^ vf;
         BR_BGE:  cond = !(sf ^ vf);
         BR_BLTU: cond = !cf;
         BR_BGEU: cond = cf;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch/jump resolution with redirect handshake and IF/ID flush
// Optional perf counters enabled by defining BRU_PERF_EN.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_is_branch,
   input  logic              ex_is_jal,
   input  logic              ex_is_jalr,
   input  logic [2:0]        ex_funct3,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [XLEN-1:0]   ex_imm,
   input  logic [XLEN-1:0]   alu_out,
   input  logic              cf,
   input  logic              zf,
   input  logic              vf,
   input  logic              sf,
   input  logic              redirect_ready,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              flush,
   output logic              stall_ex,
   output logic              misalign_exc,
   output logic              bad_funct3,
   output logic [PERF_W-1:0] perf_br_cnt,
   output logic [PERF_W-1:0] perf_tk_cnt
);

   bru_state_e      state, state_nxt;
   logic            cond, bad_raw;
   logic            is_jump, br_eff, taken, resolve, misaligned;
   logic [XLEN-1:0] target;

   branch_cond u_branch_cond (
      .funct3         (ex_funct3),
      .cf             (cf),
      .zf             (zf),
      .vf             (vf),
      .sf             (sf),
      .cond           (cond),
      .bad_funct3_raw (bad_raw)
   );

   // A jump flag overrides the branch flag, so branch checks only apply to pure branches
   assign is_jump    = ex_is_jal | ex_is_jalr;
   assign br_eff     = ex_is_branch & ~is_jump;
   assign taken      = is_jump | (br_eff & cond);
   assign target     = ex_is_jalr ? (alu_out & {{(XLEN-1){1'b1}}, 1'b0}) : (ex_pc + ex_imm);
   assign misaligned = (IALIGN == 32) && target[1];
   assign resolve    = (state == BRU_IDLE) && ex_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BRU_IDLE;
         redirect_pc  <= '0;
         misalign_exc <= 1'b0;
         bad_funct3   <= 1'b0;
      end else begin
         state        <= state_nxt;
         misalign_exc <= resolve & taken & misaligned;
         bad_funct3   <= resolve & br_eff & bad_raw;
         if (resolve && taken && !misaligned)
            redirect_pc <= target;
      end
   end

   always_comb begin
      state_nxt      = state;
      redirect_valid = 1'b0;
      stall_ex       = 1'b0;
      flush          = 1'b0;
      case (state)
         BRU_IDLE: begin
            if (resolve && taken && !misaligned)
               state_nxt = BRU_REQ;
         end
         BRU_REQ: begin
            redirect_valid = 1'b1;
            stall_ex       = 1'b1;
            if (redirect_ready)
               state_nxt = BRU_FLUSH;
         end
         BRU_FLUSH: begin
            flush     = 1'b1;
            stall_ex  = 1'b1;
            state_nxt = BRU_IDLE;
         end
         default: state_nxt = BRU_IDLE;
      endcase
   end

`ifdef BRU_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_br_cnt <= '0;
         perf_tk_cnt <= '0;
      end else begin
         if (resolve && ex_is_branch)
            perf_br_cnt <= perf_br_cnt + 1'b1;
         if (state == BRU_REQ && redirect_ready)
            perf_tk_cnt <= perf_tk_cnt + 1'b1;
      end
   end
`else
   assign perf_br_cnt = '0;
   assign perf_tk_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and randomized self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, alu_out;
   logic        cf, zf, vf, sf;
   logic        redirect_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush, stall_ex, misalign_exc, bad_funct3;
   logic [31:0] perf_br_cnt, perf_tk_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .IALIGN(32), .PERF_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jal      (ex_is_jal),
      .ex_is_jalr     (ex_is_jalr),
      .ex_funct3      (ex_funct3),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .alu_out        (alu_out),
      .cf             (cf),
      .zf             (zf),
      .vf             (vf),
      .sf             (sf),
      .redirect_ready (redirect_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .stall_ex       (stall_ex),
      .misalign_exc   (misalign_exc),
      .bad_funct3     (bad_funct3),
      .perf_br_cnt    (perf_br_cnt),
      .perf_tk_cnt    (perf_tk_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Flags as a SUB-mode ALU would produce them for a - b
   task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] diff;
      diff = a - b;
      ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
      ex_funct3 = f3; ex_pc = pc; ex_imm = imm; alu_out = alu;
      cf = (a >= b);
      zf = (a == b);
      sf = diff[31];
      vf = (a[31] != b[31]) && (diff[31] != a[31]);
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic ref_model(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] alu,
                            output logic tk, output logic [31:0] tgt, output logic bad);
      logic c;
      case (f3)
         3'd0: c = (a == b);
         3'd1: c = (a != b);
         3'd4: c = ($signed(a) <  $signed(b));
         3'd5: c = ($signed(a) >= $signed(b));
         3'd6: c = (a <  b);
         3'd7: c = (a >= b);
         default: c = 1'b0;
      endcase
      bad = 1'b0;
      if (jalr) begin
         tk = 1'b1; tgt = {alu[31:1], 1'b0};
      end else if (jal) begin
         tk = 1'b1; tgt = pc + imm;
      end else begin
         tk = br & c; tgt = pc + imm; bad = br && (f3 == 3'd2 || f3 == 3'd3);
      end
   endtask

   initial begin
      logic        tk, bad_m, v, br, jal, jalr;
      logic [31:0] tgt, a, b, pc, imm, alu;
      logic [2:0]  f3;
      int          w, kind;

      rst_n = 1'b0;
      redirect_ready = 1'b0;
      idle_in();
      step();
      chk("rst_rv", redirect_valid, 0);
      chk("rst_pc", redirect_pc, 0);
      chk("rst_flush", flush, 0);
      chk("rst_stall", stall_ex, 0);
      chk("rst_mis", misalign_exc, 0);
      chk("rst_bad", bad_funct3, 0);
      chk("rst_pbr", perf_br_cnt, 0);
      chk("rst_ptk", perf_tk_cnt, 0);
      rst_n = 1'b1;
      step();

      // BEQ taken, same-cycle ready
      redirect_ready = 1'b1;
      drive(1, 1, 0, 0, 3'd0, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5);
      step();
      chk("beq_rv", redirect_valid, 1);
      chk("beq_pc", redirect_pc, 32'h120);
      chk("beq_stall", stall_ex, 1);
      chk("beq_noflush", flush, 0);
      idle_in();
      step();
      chk("beq_flush", flush, 1);
      chk("beq_rv_off", redirect_valid, 0);
      chk("beq_flush_stall", stall_ex, 1);
      step();
      chk("beq_idle_flush", flush, 0);
      chk("beq_idle_stall", stall_ex, 0);

      // BLTU with a>=b not taken, then BGEU taken
      drive(1, 1, 0, 0, 3'd6, 32'h200, 32'h40, 32'h0, 32'd9, 32'd3);
      step();
      chk("bltu_rv", redirect_valid, 0);
      chk("bltu_stall", stall_ex, 0);
      drive(1, 1, 0, 0, 3'd7, 32'h200, 32'h40, 32'h0, 32'd9, 32'd3);
      step();
      chk("bgeu_rv", redirect_valid, 1);
      chk("bgeu_pc", redirect_pc, 32'h240);
      idle_in();
      step();
      chk("bgeu_flush", flush, 1);
      step();

      // JALR to a target with bit 1 set
      drive(1, 0, 0, 1, 3'd0, 32'h400, 32'h0, 32'h2003, 32'h0, 32'h0);
      step();
      chk("jalr_mis", misalign_exc, 1);
      chk("jalr_rv", redirect_valid, 0);
      idle_in();
      step();
      chk("jalr_mis_pulse", misalign_exc, 0);
      chk("jalr_no_rv", redirect_valid, 0);

      // Backpressure: redirect held stable, later EX activity ignored
      redirect_ready = 1'b0;
      drive(1, 0, 1, 0, 3'd0, 32'h300, 32'h10, 32'h0, 32'h0, 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("hold_rv", redirect_valid, 1);
         chk("hold_pc", redirect_pc, 32'h310);
         chk("hold_stall", stall_ex, 1);
         chk("hold_noflush", flush, 0);
         drive(1, 0, 1, 0, 3'd0, 32'h500 + i * 4, 32'h80, 32'h0, 32'h0, 32'h0);
         step();
      end
      chk("hold_rv_last", redirect_valid, 1);
      chk("hold_pc_last", redirect_pc, 32'h310);
      redirect_ready = 1'b1;
      idle_in();
      step();
      chk("hold_flush", flush, 1);
      step();
      chk("hold_idle_rv", redirect_valid, 0);

      // Target wraps modulo 2^32
      drive(1, 1, 0, 0, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'd1, 32'd1);
      step();
      chk("wrap_pc", redirect_pc, 32'h10);
      idle_in();
      step();
      step();

      // Reserved funct3
      drive(1, 1, 0, 0, 3'b010, 32'h600, 32'h20, 32'h0, 32'd1, 32'd1);
      step();
      chk("bad_f3", bad_funct3, 1);
      chk("bad_rv", redirect_valid, 0);
      idle_in();
      step();
      chk("bad_pulse", bad_funct3, 0);

      // Asynchronous reset while the redirect is pending
      redirect_ready = 1'b0;
      drive(1, 0, 1, 0, 3'd0, 32'h700, 32'h8, 32'h0, 32'h0, 32'h0);
      step();
      chk("rreq_rv", redirect_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rreq_rv0", redirect_valid, 0);
      chk("rreq_stall0", stall_ex, 0);
      chk("rreq_pc0", redirect_pc, 0);
      chk("rreq_flush0", flush, 0);
      redirect_ready = 1'b1;
      idle_in();
      step();
      rst_n = 1'b1;
      step();
      chk("rreq_noflush", flush, 0);
      chk("rreq_norv", redirect_valid, 0);

      // Three branches, two taken; counters stay 0 in the default build
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 3'd0, 32'h800, 32'h10, 32'h0, 32'd7, (i == 1) ? 32'd8 : 32'd7);
         step();
         idle_in();
         if (i != 1) begin
            step();
            step();
         end
      end
      chk("perf_br", perf_br_cnt, 0);
      chk("perf_tk", perf_tk_cnt, 0);

      // Randomized resolution against the reference model
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 5);
         br   = (kind < 4);
         jal  = (kind == 4);
         jalr = (kind == 5);
         if ($urandom_range(0, 7) == 0) br = 1'b1;
         if ($urandom_range(0, 9) == 0) jal = 1'b1;
         v    = ($urandom_range(0, 7) != 0);
         f3   = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 3) == 0) b = {~a[31], b[30:0]};
         pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         imm  = {{20{$urandom_range(0, 1) == 1}}, 12'($urandom_range(0, 4095) & 12'hFFE)};
         alu  = $urandom;
         ref_model(br, jal, jalr, f3, a, b, pc, imm, alu, tk, tgt, bad_m);
         redirect_ready = 1'b0;
         drive(v, br, jal, jalr, f3, pc, imm, alu, a, b);
         step();
         chk("rnd_rv", redirect_valid, v & tk & ~tgt[1]);
         chk("rnd_mis", misalign_exc, v & tk & tgt[1]);
         chk("rnd_bad", bad_funct3, v & bad_m);
         idle_in();
         if (v && tk && !tgt[1]) begin
            chk("rnd_pc", redirect_pc, tgt);
            w = $urandom_range(0, 3);
            for (int j = 0; j < w; j++) begin
               step();
               chk("rnd_wait_rv", redirect_valid, 1);
               chk("rnd_wait_pc", redirect_pc, tgt);
            end
            redirect_ready = 1'b1;
            step();
            chk("rnd_flush", flush, 1);
            step();
            chk("rnd_idle", stall_ex, 0);
         end else begin
            step();
            chk("rnd_nostall", stall_ex, 0);
            chk("rnd_noflush", flush, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
